// File: rtl/mul_issue_pkg.sv
// Shared definitions for the multiply issue unit.
// Holds the FSM state encoding, the RV32M decode constants for the
// multiply family and the default multiplier latency.
package mul_issue_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } mul_state_e;

   localparam logic [6:0] OPCODE_OP     = 7'b0110011;
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;

   localparam int MUL_LATENCY_DEFAULT = 3;

endpackage

// File: rtl/mul_issue_unit.sv
// Multiply issue unit: detects MUL/MULH/MULHSU/MULHU in ID/EX, latches the
// operands, drives an external pipelined multiplier for LATENCY enabled
// edges, then presents the product to EX/MEM with a valid/ready handshake.
//
// Ports
//   clk, reset                        clock, async active-high reset
//   in_valid/opcode/funct7/funct3     ID/EX instruction fields
//   in_rs1_val, in_rs2_val, in_rd     forwarded operands and destination
//   flush                             abandon any in-flight operation
//   mul_ce, mul_a, mul_b, mul_funct3  multiplier enable, operands, op select
//   mul_result                        multiplier product
//   stall                             freeze IF/ID and ID/EX
//   out_valid, out_result, out_rd     completed result
//   out_ready                         downstream accepts the result
//   busy                              unit not idle
//
// state | meaning
// IDLE  | waiting for an acceptable multiply
// RUN   | multiplier enabled, counting down to capture
// DONE  | result held until out_ready
module mul_issue_unit
   import mul_issue_pkg::*;
#(
   parameter int LATENCY = MUL_LATENCY_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [6:0]  in_opcode,
   input  logic [6:0]  in_funct7,
   input  logic [2:0]  in_funct3,
   input  logic [31:0] in_rs1_val,
   input  logic [31:0] in_rs2_val,
   input  logic [4:0]  in_rd,
   input  logic        flush,
   output logic        mul_ce,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   output logic [2:0]  mul_funct3,
   input  logic [31:0] mul_result,
   output logic        stall,
   output logic        out_valid,
   output logic [31:0] out_result,
   output logic [4:0]  out_rd,
   input  logic        out_ready,
   output logic        busy
);

   localparam int            CW       = $clog2(LATENCY + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY);

   mul_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   a_q, a_d, b_q, b_d, res_q, res_d;
   logic [2:0]    f3_q, f3_d;
   logic [4:0]    rd_q, rd_d;

   logic is_mul, acc_ok, load, capture;

   // Writes to x0 are architecturally dead, so they never occupy the unit.
   assign is_mul = in_valid && (in_opcode == OPCODE_OP) &&
                   (in_funct7 == FUNCT7_MULDIV) && !in_funct3[2];
   assign acc_ok = is_mul && (in_rd != 5'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (acc_ok) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == '0) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = acc_ok ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      mul_ce    = 1'b0;
      busy      = 1'b0;
      out_valid = 1'b0;
      stall     = 1'b0;
      load      = 1'b0;
      capture   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            stall = acc_ok;
            load  = acc_ok && !flush;
         end
         ST_RUN: begin
            mul_ce  = 1'b1;
            busy    = 1'b1;
            stall   = 1'b1;
            capture = (cnt_q == '0) && !flush;
         end
         ST_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            stall     = !out_ready;
            load      = out_ready && acc_ok && !flush;
         end
         default: ;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      a_d   = a_q;
      b_d   = b_q;
      f3_d  = f3_q;
      rd_d  = rd_q;
      res_d = res_q;
      if (flush) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = CNT_LOAD;
         a_d   = in_rs1_val;
         b_d   = in_rs2_val;
         f3_d  = in_funct3;
         rd_d  = in_rd;
      end else if ((state_q == ST_RUN) && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
      if (capture) res_d = mul_result;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
         f3_q  <= '0;
         rd_q  <= '0;
         res_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         a_q   <= a_d;
         b_q   <= b_d;
         f3_q  <= f3_d;
         rd_q  <= rd_d;
         res_q <= res_d;
      end
   end

   assign mul_a      = a_q;
   assign mul_b      = b_q;
   assign mul_funct3 = f3_q;
   assign out_result = res_q;
   assign out_rd     = rd_q;

endmodule

// File: tb/tb_mul_issue_unit.sv
// Directed bench for mul_issue_unit with a 3-stage multiplier model.
module tb_mul_issue_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [6:0]  in_opcode, in_funct7;
   logic [2:0]  in_funct3;
   logic [31:0] in_rs1_val, in_rs2_val;
   logic [4:0]  in_rd;
   logic        flush;
   logic        mul_ce;
   logic [31:0] mul_a, mul_b;
   logic [2:0]  mul_funct3;
   logic [31:0] mul_result;
   logic        stall, out_valid, out_ready, busy;
   logic [31:0] out_result;
   logic [4:0]  out_rd;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mul_issue_unit dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_opcode(in_opcode),
      .in_funct7(in_funct7), .in_funct3(in_funct3), .in_rs1_val(in_rs1_val),
      .in_rs2_val(in_rs2_val), .in_rd(in_rd), .flush(flush), .mul_ce(mul_ce),
      .mul_a(mul_a), .mul_b(mul_b), .mul_funct3(mul_funct3),
      .mul_result(mul_result), .stall(stall), .out_valid(out_valid),
      .out_result(out_result), .out_rd(out_rd), .out_ready(out_ready),
      .busy(busy)
   );

   // Multiplier model: three enabled stages, product computed from operands.
   function automatic logic [31:0] mprod(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] ea, eb, p;
      ea = {32'b0, a};
      eb = {32'b0, b};
      if (f3 == 3'b001 || f3 == 3'b010) ea = {{32{a[31]}}, a};
      if (f3 == 3'b001)                 eb = {{32{b[31]}}, b};
      p = ea * eb;
      return (f3 == 3'b000) ? p[31:0] : p[63:32];
   endfunction

   logic [31:0] s1, s2, s3;
   always @(posedge clk) begin
      if (mul_ce) begin
         s1 <= mprod(mul_funct3, mul_a, mul_b);
         s2 <= s1;
         s3 <= s2;
      end
   end
   assign mul_result = s3;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [6:0] op, input logic [6:0] f7,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
      in_valid   = 1'b1;
      in_opcode  = op;
      in_funct7  = f7;
      in_funct3  = f3;
      in_rs1_val = a;
      in_rs2_val = b;
      in_rd      = rd;
      #1;
   endtask

   task automatic idle_in();
      in_valid = 1'b0;
      #1;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_opcode = '0; in_funct7 = '0;
      in_funct3 = '0; in_rs1_val = '0; in_rs2_val = '0; in_rd = '0;
      flush = 1'b0; out_ready = 1'b1;
      tick(); tick();

      chk("rst_stall", {31'b0, stall}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_ce", {31'b0, mul_ce}, 0);
      chk("rst_valid", {31'b0, out_valid}, 0);
      chk("rst_result", out_result, 0);
      chk("rst_rd", {27'b0, out_rd}, 0);
      chk("rst_a", mul_a, 0);
      chk("rst_f3", {29'b0, mul_funct3}, 0);
      reset = 1'b0;
      tick();

      // MUL 7*6 -> 42, valid only in cycle 5, stall cycles 0-4
      drive(7'b0110011, 7'b0000001, 3'b000, 32'd7, 32'd6, 5'd5);
      for (int c = 0; c <= 6; c++) begin
         chk($sformatf("t1_stall_c%0d", c), {31'b0, stall}, {31'b0, c <= 4});
         chk($sformatf("t1_valid_c%0d", c), {31'b0, out_valid}, {31'b0, c == 5});
         chk($sformatf("t1_ce_c%0d", c), {31'b0, mul_ce},
             {31'b0, (c >= 1 && c <= 4)});
         if (c == 5) begin
            chk("t1_result", out_result, 32'd42);
            chk("t1_rd", {27'b0, out_rd}, 32'd5);
            chk("t1_held_a", mul_a, 32'd7);
         end
         tick();
         if (c == 0) idle_in();
      end
      chk("t1_busy_after", {31'b0, busy}, 0);

      // MULHU 0xFFFFFFFF^2 with out_ready low for 4 DONE cycles
      out_ready = 1'b0;
      drive(7'b0110011, 7'b0000001, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
      tick(); idle_in();
      tick(); tick(); tick(); tick();
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("t2_valid_w%0d", c), {31'b0, out_valid}, 1);
         chk($sformatf("t2_result_w%0d", c), out_result, 32'hFFFF_FFFE);
         chk($sformatf("t2_stall_w%0d", c), {31'b0, stall}, 1);
         chk($sformatf("t2_ce_w%0d", c), {31'b0, mul_ce}, 0);
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("t2_stall_rdy", {31'b0, stall}, 0);
      chk("t2_valid_rdy", {31'b0, out_valid}, 1);
      tick();
      chk("t2_busy_after", {31'b0, busy}, 0);

      // back-to-back: MUL 3*5, then MULH 0x80000000*2 offered in DONE
      drive(7'b0110011, 7'b0000001, 3'b000, 32'd3, 32'd5, 5'd7);
      tick(); idle_in();
      tick(); tick(); tick(); tick();
      chk("t3_valid1", {31'b0, out_valid}, 1);
      chk("t3_result1", out_result, 32'd15);
      drive(7'b0110011, 7'b0000001, 3'b001, 32'h8000_0000, 32'd2, 5'd9);
      chk("t3_stall_done", {31'b0, stall}, 0);
      tick(); idle_in();
      chk("t3_run_direct", {31'b0, mul_ce}, 1);
      chk("t3_latched_a", mul_a, 32'h8000_0000);
      for (int c = 6; c <= 10; c++) begin
         chk($sformatf("t3_valid_c%0d", c), {31'b0, out_valid}, {31'b0, c == 10});
         if (c < 10) tick();
      end
      chk("t3_result2", out_result, 32'hFFFF_FFFF);
      chk("t3_rd2", {27'b0, out_rd}, 32'd9);
      tick();

      // flush in RUN when counter=1 (cycle 3)
      drive(7'b0110011, 7'b0000001, 3'b000, 32'd10, 32'd10, 5'd2);
      tick(); idle_in();
      tick(); tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t4_busy", {31'b0, busy}, 0);
      chk("t4_stall", {31'b0, stall}, 0);
      chk("t4_ce", {31'b0, mul_ce}, 0);
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("t4_novalid_%0d", c), {31'b0, out_valid}, 0);
         tick();
      end

      // ignored instructions: rd=0 MUL, DIV, non-M ADD
      drive(7'b0110011, 7'b0000001, 3'b000, 32'd4, 32'd4, 5'd0);
      chk("t5_rd0_stall", {31'b0, stall}, 0);
      tick();
      chk("t5_rd0_busy", {31'b0, busy}, 0);
      chk("t5_rd0_ce", {31'b0, mul_ce}, 0);
      drive(7'b0110011, 7'b0000001, 3'b100, 32'd8, 32'd2, 5'd3);
      chk("t5_div_stall", {31'b0, stall}, 0);
      tick();
      chk("t5_div_busy", {31'b0, busy}, 0);
      chk("t5_div_ce", {31'b0, mul_ce}, 0);
      drive(7'b0110011, 7'b0000000, 3'b000, 32'd8, 32'd2, 5'd3);
      chk("t5_add_stall", {31'b0, stall}, 0);
      tick();
      chk("t5_add_busy", {31'b0, busy}, 0);
      idle_in();

      // reset while in DONE, then a normal MUL
      out_ready = 1'b0;
      drive(7'b0110011, 7'b0000001, 3'b000, 32'd9, 32'd9, 5'd4);
      tick(); idle_in();
      tick(); tick(); tick(); tick();
      chk("t6_done_valid", {31'b0, out_valid}, 1);
      chk("t6_done_result", out_result, 32'd81);
      reset = 1'b1;
      #1;
      chk("t6_rst_valid", {31'b0, out_valid}, 0);
      chk("t6_rst_result", out_result, 0);
      chk("t6_rst_rd", {27'b0, out_rd}, 0);
      chk("t6_rst_busy", {31'b0, busy}, 0);
      chk("t6_rst_stall", {31'b0, stall}, 0);
      chk("t6_rst_b", mul_b, 0);
      tick();
      reset = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("t6_novalid_%0d", c), {31'b0, out_valid}, 0);
         tick();
      end
      drive(7'b0110011, 7'b0000001, 3'b000, 32'd11, 32'd12, 5'd6);
      tick(); idle_in();
      tick(); tick(); tick();
      chk("t6_c4_valid", {31'b0, out_valid}, 0);
      tick();
      chk("t6_c5_valid", {31'b0, out_valid}, 1);
      chk("t6_c5_result", out_result, 32'd132);
      chk("t6_c5_rd", {27'b0, out_rd}, 32'd6);
      tick();
      chk("t6_idle", {31'b0, busy}, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mul_issue_unit.md
MUL_ISSUE_UNIT -- requirements
Module: mul_issue_unit

Interface
REQ-001 Parameter LATENCY, default 3, SHALL be the number of rising edges with mul_ce high after which mul_result is valid for held operands.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  ID/EX slot holds a valid instruction.
REQ-005 in_opcode  input  7  instruction opcode.
REQ-006 in_funct7  input  7  instruction funct7.
REQ-007 in_funct3  input  3  instruction funct3.
REQ-008 in_rs1_val, in_rs2_val  input  32 each  forwarded source operands.
REQ-009 in_rd  input  5  destination register.
REQ-010 flush  input  1  kill any in-flight operation.
REQ-011 mul_ce, mul_a, mul_b, mul_funct3  output  1/32/32/3  enable, operands and op select to the multiplier.
REQ-012 mul_result  input  32  product selected by the multiplier for mul_funct3.
REQ-013 stall  output  1  freeze IF/ID and ID/EX.
REQ-014 out_valid, out_result, out_rd  output  1/32/5  completed result toward EX/MEM.
REQ-015 out_ready  input  1  downstream accepts out_* this cycle.
REQ-016 busy  output  1  state is not IDLE.

Function
REQ-017 An instruction SHALL be a mul op when in_valid=1, in_opcode=0110011, in_funct7=0000001, in_funct3[2]=0.
REQ-018 A mul op with in_rd=0 SHALL NOT be accepted and SHALL NOT raise stall.
REQ-019 FSM SHALL have states IDLE, RUN, DONE.
REQ-020 IDLE: on an acceptable mul op, latch rs1/rs2/funct3/rd, load counter with LATENCY, go RUN.
REQ-021 RUN: mul_ce=1; counter decrements each edge while nonzero; at the edge where counter=0, capture mul_result into out_result, go DONE.
REQ-022 DONE: out_valid=1, out_result and out_rd held stable until out_ready=1.
REQ-023 DONE with out_ready=1 SHALL go IDLE, or directly RUN (new latch, counter reload) if an acceptable mul op is present the same cycle.
REQ-024 mul_a/mul_b/mul_funct3 SHALL come only from the latched registers and stay constant from entering RUN until leaving DONE.
REQ-025 stall SHALL be combinationally 1 in IDLE when an acceptable mul op is present, in RUN, and in DONE while out_ready=0; 0 otherwise.
REQ-026 Latency: with LATENCY=3 and out_ready=1, in_valid at cycle 0 SHALL yield out_valid high in cycle 5 only.
REQ-027 flush=1 SHALL force IDLE at the next edge from any state, clear out_valid and suppress capture; flush has priority over accept and over out_ready.
REQ-028 funct3 1xx (divide family) and non-M opcodes SHALL be ignored: no accept, no stall.
REQ-029 mul_ce SHALL be 0 in IDLE and DONE.
REQ-030 Counter width SHALL be $clog2(LATENCY+1); LATENCY=1 SHALL be supported.

Reset
REQ-031 On reset: state=IDLE, counter=0, out_valid=0, out_result=0, out_rd=0, latched operands/funct3=0; hence stall=0, busy=0, mul_ce=0.
REQ-032 Reset asserted mid-RUN or in DONE SHALL discard the operation with no out_valid pulse after release.

Structure
REQ-033 Package mul_issue_pkg SHALL hold the state enum, OPCODE_OP, FUNCT7_MULDIV, funct3 codes MUL/MULH/MULHSU/MULHU, and default LATENCY.
REQ-034 Single flat module; no sub-module; the multiplier is instantiated by the parent and connected through mul_*.

Verification
REQ-035 MUL rs1=7, rs2=6, rd=5, out_ready=1, model product after 3 ce edges -> out_valid in cycle 5, out_result=42, out_rd=5, stall high cycles 0-4.
REQ-036 MULHU 0xFFFFFFFF*0xFFFFFFFF, out_ready=0 for 4 cycles in DONE -> out_result=0xFFFFFFFE held, stall high until out_ready.
REQ-037 Back-to-back: second MUL present in DONE with out_ready=1 -> RUN entered directly, second result 5 cycles after first.
REQ-038 flush in RUN with counter=1 -> IDLE next cycle, out_valid never asserted, stall=0.
REQ-039 rd=0 MUL, and DIV (funct3=100) -> no accept, stall=0, mul_ce=0.
REQ-040 Reset pulse in DONE -> all outputs 0; following MUL completes normally.
